// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the main-memory port between icache (loads) and dcache
// (loads/stores): latches operands on grant, routes responses, inserts a dead gap, times out.
package constants_pkg;
  localparam int PHY_LEN = 20;
  localparam int MBLEN   = 128;
endpackage

module mem_port_arbiter
  import constants_pkg::*;
#(
  parameter int ADDR_W  = PHY_LEN,
  parameter int LINE_W  = MBLEN,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ldp,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ldr,
  output logic [LINE_W-1:0] i_ldData,
  input  logic              d_ldp,
  input  logic              d_srp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_srData,
  output logic              d_ldr,
  output logic              d_srr,
  output logic [LINE_W-1:0] d_ldData,
  output logic              mem_ldp,
  output logic              mem_srp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_srData,
  input  logic              mem_ldr,
  input  logic              mem_srr,
  input  logic [LINE_W-1:0] mem_ldData,
  output logic [1:0]        grant,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q;
  logic              last_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic [1:0]        grant_q;
  logic              mem_ldp_q;
  logic              mem_srp_q;

  logic i_pend;
  logic d_pend;
  logic pick_d;
  logic resp;
  logic busy;

  // last_q = 1 means dcache was granted most recently; on a tie the other side wins.
  assign i_pend = i_ldp;
  assign d_pend = d_ldp | d_srp;
  assign pick_d = d_pend & (~i_pend | ~last_q);
  assign resp   = mem_ldr | mem_srr;
  assign busy   = (state_q == BUSY);
  assign cnt_d  = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      grant_q   <= 2'b00;
      mem_ldp_q <= 1'b0;
      mem_srp_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pend | d_pend) begin
            state_q <= BUSY;
            cnt_q   <= 8'd0;
            if (pick_d) begin
              addr_q    <= d_addr;
              data_q    <= d_srData;
              grant_q   <= OWN_D;
              last_q    <= 1'b1;
              mem_ldp_q <= ~d_srp;
              mem_srp_q <= d_srp;
            end else begin
              addr_q    <= i_addr;
              grant_q   <= OWN_I;
              last_q    <= 1'b0;
              mem_ldp_q <= 1'b1;
              mem_srp_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (resp || cnt_q == CNT_LAST) begin
            state_q   <= GAP;
            grant_q   <= 2'b00;
            mem_ldp_q <= 1'b0;
            mem_srp_q <= 1'b0;
            if (!resp) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses outside BUSY are dropped; grant_q is only non-zero while BUSY.
  assign i_ldr = busy & mem_ldr & (grant_q == OWN_I);
  assign d_ldr = busy & mem_ldr & (grant_q == OWN_D);
  assign d_srr = busy & mem_srr & (grant_q == OWN_D);

  assign i_ldData   = mem_ldData;
  assign d_ldData   = mem_ldData;
  assign mem_ldp    = mem_ldp_q;
  assign mem_srp    = mem_srp_q;
  assign mem_addr   = addr_q;
  assign mem_srData = data_q;
  assign grant      = grant_q;
  assign err        = err_q;

endmodule
